mod_n_checker: RTL and testbench

Receive-side checker for a mod-N counter stream. It samples a WIDTH-bit count value, locks onto the 0..N-1 wrap sequence and reports sequence errors and wraps. It sits downstream of the mod-N counter, in the bench or in a system monitor, to confirm the counter output is legal.

---
 rtl/mod_n_checker_if.sv | 25 ++
 rtl/mod_n_checker.sv | 160 ++++++++++++++++
 tb/tb_mod_n_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mod_n_checker_if.sv
// Count-stream interface between a mod-N counter source and its checker.
// The master drives the sampled count; the slave (checker) returns lock/error status.
interface mod_n_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] count_in;
    logic             locked;
    logic [WIDTH-1:0] expected;
    logic             wrap_pulse;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             err_sticky;

    modport master (
        output in_valid, count_in,
        input  locked, expected, wrap_pulse, err_pulse, err_count, err_sticky
    );

    modport slave (
        input  in_valid, count_in,
        output locked, expected, wrap_pulse, err_pulse, err_count, err_sticky
    );
endinterface

// File: rtl/mod_n_checker.sv
// Receive-side checker for a mod-N count stream: locks onto 0..N-1 and reports wraps/errors.
// Define MODN_CHK_STICKY_EN to build the sticky error flag; otherwise err_sticky is tied low.
module mod_n_checker #(
    parameter int unsigned N        = 12,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input logic            clk,
    input logic            rst,
    mod_n_checker_if.slave bus
);

    localparam int unsigned CNT_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [WIDTH:0]   N_X        = (WIDTH+1)'(N);
    localparam logic [WIDTH:0]   LAST_X     = (WIDTH+1)'(N - 1);
    localparam logic [CNT_W-1:0] LOCK_X     = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [1:0]       SEED_STATE = (LOCK_CNT == 1) ? LOCKED : SYNC;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [ERR_W-1:0] errc_q, errc_d;
    logic             locked_q;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   cnt_x;
    logic             in_range;
    logic             hit;
    logic             is_last;
    logic [WIDTH-1:0] nxt;
    logic [CNT_W-1:0] mcnt_inc;

    // Successor in WIDTH+1 bits so N == 2^WIDTH cannot overflow before the wrap test.
    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = {1'b0, x} + (WIDTH+1)'(1);
        if ({1'b0, x} == LAST_X) begin
            return '0;
        end
        return s[WIDTH-1:0];
    endfunction

    assign cnt_x    = {1'b0, bus.count_in};
    assign in_range = (cnt_x < N_X);
    assign hit      = (bus.count_in == exp_q);
    assign is_last  = (cnt_x == LAST_X);
    assign nxt      = next_val(bus.count_in);
    assign mcnt_inc = mcnt_q + ONE_C;

    // Next-state and next-output decode; idle cycles hold state and clear pulses.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mcnt_d  = mcnt_q;
        errc_d  = errc_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_range) begin
                        exp_d   = nxt;
                        mcnt_d  = ONE_C;
                        state_d = SEED_STATE;
                    end
                end
                SYNC: begin
                    if (hit) begin
                        exp_d  = nxt;
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc >= LOCK_X) begin
                            state_d = LOCKED;
                        end
                    end else if (in_range) begin
                        exp_d   = nxt;
                        mcnt_d  = ONE_C;
                        state_d = SEED_STATE;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        exp_d  = nxt;
                        wrap_d = is_last;
                    end else begin
                        err_d = 1'b1;
                        if (errc_q != ERR_MAX) begin
                            errc_d = errc_q + ERR_W'(1);
                        end
                        if (in_range) begin
                            exp_d   = nxt;
                            mcnt_d  = ONE_C;
                            state_d = SEED_STATE;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State and registered outputs; rst wins over any sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            mcnt_q   <= '0;
            errc_q   <= '0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            mcnt_q   <= mcnt_d;
            errc_q   <= errc_d;
            locked_q <= (state_d == LOCKED);
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

`ifdef MODN_CHK_STICKY_EN
    logic sticky_q;

    // Latches the first error seen since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (err_d) begin
            sticky_q <= 1'b1;
        end
    end

    assign bus.err_sticky = sticky_q;
`else
    assign bus.err_sticky = 1'b0;
`endif

    assign bus.locked     = locked_q;
    assign bus.expected   = exp_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.err_pulse  = err_q;
    assign bus.err_count  = errc_q;

endmodule

// File: tb/tb_mod_n_checker.sv
// Scoreboard bench for mod_n_checker: directed scenarios plus random stream against an
// arithmetic reference model; two instances share stimulus (8-bit and 2-bit error counters).
module tb_mod_n_checker;

    localparam int N        = 12;
    localparam int LOCK_CNT = 2;

    typedef struct {
        bit locked;
        int exp;
        bit wrap;
        bit err;
        int errs;
        bit sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mod_n_checker_if #(.WIDTH(4), .ERR_W(8)) bus8 ();
    mod_n_checker_if #(.WIDTH(4), .ERR_W(2)) bus2 ();

    mod_n_checker #(.N(12), .WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );
    mod_n_checker #(.N(12), .WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model: last expected value, length of current in-sequence run, lock flag.
    int m_exp = 0;
    int m_run = 0;
    bit m_locked = 0;
    int m_errs = 0;
    bit m_sticky = 0;

    task automatic drive(input bit r, input bit v, input int x);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus8.in_valid = v;
        bus8.count_in = 4'(x);
        bus2.in_valid = v;
        bus2.count_in = 4'(x);
        e.wrap = 0;
        e.err  = 0;
        if (r) begin
            m_exp = 0; m_run = 0; m_locked = 0; m_errs = 0; m_sticky = 0;
        end else if (v) begin
            if (m_locked) begin
                if (x == m_exp) begin
                    e.wrap = (x == N - 1);
                    m_exp  = (x + 1) % N;
                end else begin
                    e.err = 1;
                    m_errs++;
                    m_sticky = 1;
                    if (x < N) begin
                        m_run    = 1;
                        m_exp    = (x + 1) % N;
                        m_locked = (LOCK_CNT == 1);
                    end else begin
                        m_run    = 0;
                        m_locked = 0;
                    end
                end
            end else if (x >= N) begin
                m_run = 0;
            end else if (m_run > 0 && x == m_exp) begin
                m_run++;
                m_exp = (x + 1) % N;
                if (m_run >= LOCK_CNT) m_locked = 1;
            end else begin
                m_run    = 1;
                m_exp    = (x + 1) % N;
                m_locked = (LOCK_CNT == 1);
            end
        end
        e.locked = m_locked;
        e.exp    = m_exp;
        e.errs   = m_errs;
        e.sticky = m_sticky;
        q.push_back(e);
    endtask

    function automatic void chk(input string nm, input logic l, input logic [3:0] ex,
                                input logic w, input logic er, input int ec,
                                input logic st, input exp_t e, input int emax);
        int  w_ec;
        bit  w_st;
        w_ec = (e.errs > emax) ? emax : e.errs;
`ifdef MODN_CHK_STICKY_EN
        w_st = e.sticky;
`else
        w_st = 0;
`endif
        vectors++;
        if ({l, ex, w, er, st} !== {e.locked, 4'(e.exp), e.wrap, e.err, w_st} || ec != w_ec) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got locked=%b exp=%0d wrap=%b err=%b errc=%0d sticky=%b want locked=%b exp=%0d wrap=%b err=%b errc=%0d sticky=%b",
                     nm, cyc, l, ex, w, er, ec, st, e.locked, e.exp, e.wrap, e.err, w_ec, w_st);
        end
    endfunction

    // Monitor: every registered output cycle with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dut8", bus8.locked, bus8.expected, bus8.wrap_pulse, bus8.err_pulse,
                    int'(bus8.err_count), bus8.err_sticky, e, 255);
                chk("dut2", bus2.locked, bus2.expected, bus2.wrap_pulse, bus2.err_pulse,
                    int'(bus2.err_count), bus2.err_sticky, e, 3);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst           = 1'b1;
        bus8.in_valid = 1'b0;
        bus8.count_in = '0;
        bus2.in_valid = 1'b0;
        bus2.count_in = '0;

        // Reset, full sequence with a wrap, then an error and relock.
        drive(1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 14; i++) drive(0, 1, i % N);
        for (int i = 2; i <= 4; i++) drive(0, 1, i);
        drive(0, 1, 5); drive(0, 1, 7); drive(0, 1, 8); drive(0, 1, 9);

        // Out-of-range values never lock or count errors.
        drive(1, 1, 0);
        drive(0, 1, 13); drive(0, 1, 14); drive(0, 1, 15); drive(0, 1, 12);

        // Idle gap with a bogus count keeps lock and expected.
        for (int i = 0; i <= 3; i++) drive(0, 1, i);
        for (int i = 0; i < 3; i++) drive(0, 0, 9);
        drive(0, 1, 4);

        // Repeated errors with relock: saturates the 2-bit counter, then the 8-bit one.
        for (int i = 0; i < 262; i++) begin
            drive(0, 1, (m_exp + 5) % N);
            drive(0, 1, m_exp);
        end
        drive(0, 1, 15);

        // Reset mid-lock overrides an in-sequence sample, then relock.
        drive(1, 1, 0);
        drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 2);
        drive(1, 1, m_exp);
        drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 2);

        // Random stream biased toward in-sequence samples.
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int c, x;
            r = ($urandom_range(99) == 0);
            v = ($urandom_range(99) < 85);
            c = $urandom_range(9);
            if (c < 7)       x = m_exp;
            else if (c < 8)  x = $urandom_range(15);
            else             x = $urandom_range(N - 1);
            drive(r, v, x);
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
